// File: rtl/alu_uart_interface_if.sv
// rtl/alu_uart_interface_if.sv - signal bundle between the UART pair, the ALU and the byte sequencer
interface alu_uart_interface_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;

  modport master (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy
  );

  modport slave (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy
  );
endinterface

// File: rtl/alu_uart_interface.sv
// rtl/alu_uart_interface.sv - UART byte sequencer feeding A, B, opcode to the ALU and returning the result
// Optional inter-byte watchdog enabled by defining ALU_UART_IF_TIMEOUT_EN.
module alu_uart_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  alu_uart_interface_if.master  bus
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic load_a;
  logic load_b;
  logic load_op;
  logic tmo_hit;

  logic [NB_DATA-1:0] data_a_q;
  logic [NB_DATA-1:0] data_b_q;
  logic [NB_OP-1:0]   op_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_start_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  // A byte arriving with the watchdog expiry wins over the timeout.
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    case (state)
      WAIT_A: begin
        if (bus.i_rx_done) begin
          load_a     = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.i_rx_done) begin
          load_b     = 1'b1;
          state_next = WAIT_OP;
        end else if (tmo_hit) begin
          state_next = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (bus.i_rx_done) begin
          load_op    = 1'b1;
          state_next = EXEC;
        end else if (tmo_hit) begin
          state_next = WAIT_A;
        end
      end
      EXEC: begin
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.i_tx_done) begin
          state_next = WAIT_A;
        end
      end
      default: begin
        state_next = WAIT_A;
      end
    endcase
  end

  // EXEC follows the opcode edge, so the ALU has had a full cycle on the new operands.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      if (load_a) begin
        data_a_q <= bus.i_rx_data;
      end
      if (load_b) begin
        data_b_q <= bus.i_rx_data;
      end
      if (load_op) begin
        op_q <= bus.i_rx_data[NB_OP-1:0];
      end
      if (state == EXEC) begin
        tx_data_q <= bus.i_alu_result;
      end
      tx_start_q <= (state == EXEC);
    end
  end

`ifdef ALU_UART_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             waiting;

  assign waiting = (state == WAIT_B) || (state == WAIT_OP);
  // Expiry fires on the edge where the idle count would reach TIMEOUT_CYCLES.
  assign tmo_hit = waiting && !bus.i_rx_done && (idle_cnt == CNT_LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      idle_cnt <= '0;
    end else if (!waiting || bus.i_rx_done || tmo_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  assign bus.o_data_a   = data_a_q;
  assign bus.o_data_b   = data_b_q;
  assign bus.o_op       = op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = (state == EXEC) || (state == WAIT_TX);

endmodule

// File: tb/tb_alu_uart_interface.sv
// tb/tb_alu_uart_interface.sv - self-checking bench for alu_uart_interface (honours ALU_UART_IF_TIMEOUT_EN)
module tb_alu_uart_interface;

  localparam int TMO = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_uart_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_interface #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.i_alu_result = alu(bus.o_data_a, bus.o_data_b, bus.o_op);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: bytes fill slots 0..2, then one busy period until tx done.
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  bit         m_start, m_busy;
  int         got, age, idle;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
      m_start = 0; m_busy = 0; got = 0; age = 0; idle = 0;
    end else begin
      m_start = 0;
      if (m_busy) begin
        if (age == 0) begin
          m_tx    = alu(m_a, m_b, m_op);
          m_start = 1;
          age     = 1;
        end else if (bus.i_tx_done) begin
          m_busy = 0;
        end
      end else if (bus.i_rx_done) begin
        if (got == 0) m_a = bus.i_rx_data;
        else if (got == 1) m_b = bus.i_rx_data;
        else m_op = bus.i_rx_data[5:0];
        got++;
        idle = 0;
        if (got == 3) begin
          got    = 0;
          m_busy = 1;
          age    = 0;
        end
      end
`ifdef ALU_UART_IF_TIMEOUT_EN
      else if (got != 0) begin
        idle++;
        if (idle == TMO) begin
          got  = 0;
          idle = 0;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_data_a",   bus.o_data_a,   m_a);
      chk("cyc_data_b",   bus.o_data_b,   m_b);
      chk("cyc_op",       bus.o_op,       m_op);
      chk("cyc_tx_data",  bus.o_tx_data,  m_tx);
      chk("cyc_tx_start", bus.o_tx_start, m_start);
      chk("cyc_busy",     bus.o_busy,     m_busy);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic txdone();
    @(negedge clk);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_a"},     bus.o_data_a,   0);
    chk({nm, "_b"},     bus.o_data_b,   0);
    chk({nm, "_op"},    bus.o_op,       0);
    chk({nm, "_tx"},    bus.o_tx_data,  0);
    chk({nm, "_start"}, bus.o_tx_start, 0);
    chk({nm, "_busy"},  bus.o_busy,     0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;

    // Basic: 1 + 1
    send(8'h01);
    send(8'h01);
    send(8'h20);
    chk("basic_a", bus.o_data_a, 8'h01);
    chk("basic_b", bus.o_data_b, 8'h01);
    chk("basic_op", bus.o_op, 6'h20);
    chk("basic_busy_n", bus.o_busy, 1'b1);
    chk("basic_start_n", bus.o_tx_start, 1'b0);
    @(negedge clk);
    chk("basic_start_n1", bus.o_tx_start, 1'b1);
    chk("basic_tx", bus.o_tx_data, 8'h02);
    txdone();
    chk("basic_idle", bus.o_busy, 1'b0);
    chk("basic_tx_hold", bus.o_tx_data, 8'h02);

    // Opcode truncation: 0xE2 -> 0x22 (subtract)
    send(8'h03);
    send(8'h04);
    send(8'hE2);
    chk("trunc_op", bus.o_op, 6'h22);
    @(negedge clk);
    chk("trunc_tx", bus.o_tx_data, 8'hFF);
    txdone();

    // Bytes dropped while busy
    send(8'h10);
    send(8'h20);
    send(8'h20);
    send(8'h55);
    send(8'h55);
    chk("drop_a", bus.o_data_a, 8'h10);
    chk("drop_b", bus.o_data_b, 8'h20);
    txdone();
    send(8'h03);
    send(8'h04);
    send(8'h20);
    @(negedge clk);
    chk("drop_tx", bus.o_tx_data, 8'h07);
    txdone();

    // Simultaneous rx_done and tx_done in WAIT_TX
    send(8'h01);
    send(8'h02);
    send(8'h20);
    @(negedge clk);
    bus.i_rx_data = 8'h09;
    bus.i_rx_done = 1'b1;
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    chk("simul_a", bus.o_data_a, 8'h01);
    chk("simul_busy", bus.o_busy, 1'b0);
    send(8'h0A);
    chk("simul_next_a", bus.o_data_a, 8'h0A);
    send(8'h01);
    send(8'h20);
    @(negedge clk);
    chk("simul_tx", bus.o_tx_data, 8'h0B);
    txdone();

    // Asynchronous reset mid-transaction
    send(8'h11);
    chk("rst_pre_a", bus.o_data_a, 8'h11);
    #2 rst_n = 1'b0;
    #1 all_zero("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h05);
    send(8'h06);
    send(8'h20);
    @(negedge clk);
    chk("rst_tx", bus.o_tx_data, 8'h0B);
    txdone();

    // Inter-byte idle
    send(8'h01);
    repeat (TMO) @(negedge clk);
    send(8'h02);
`ifdef ALU_UART_IF_TIMEOUT_EN
    chk("tmo_a", bus.o_data_a, 8'h02);
`else
    chk("tmo_a", bus.o_data_a, 8'h01);
    chk("tmo_b", bus.o_data_b, 8'h02);
`endif
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

Byte-level sequencer between a UART receiver/transmitter pair and the combinational ALU. It collects three received bytes in order: operand A, operand B, then the opcode. It drives these to the ALU, captures the ALU result one cycle later and hands it to the UART transmitter, then waits for transmit completion. It is the serial-link replacement for the button/switch operand-loading path in the board top level.

## Interface
- `NB_DATA`, 8, width of operands, result and UART byte
- `NB_OP`, 6, opcode width; taken from the low `NB_OP` bits of the opcode byte
- `TIMEOUT_CYCLES`, 1000000, idle limit for the inter-byte watchdog; used only with `ALU_UART_IF_TIMEOUT_EN`
- `i_clock`  in  1  system clock; all state updates on the rising edge
- `i_reset`  in  1  asynchronous reset, active-low
  - forces every register to its reset value immediately while low
- `i_rx_data`  in  NB_DATA  received byte; valid while `i_rx_done`=1
- `i_rx_done`  in  1  one-cycle pulse, one received byte
- `i_alu_result`  in  NB_DATA  combinational ALU output for the current `o_data_a`/`o_data_b`/`o_op`
- `i_tx_done`  in  1  one-cycle pulse, transmitter finished the byte
- `o_data_a`  out  NB_DATA  registered operand A to the ALU
- `o_data_b`  out  NB_DATA  registered operand B to the ALU
- `o_op`  out  NB_OP  registered opcode to the ALU
- `o_tx_data`  out  NB_DATA  registered result byte to the transmitter
- `o_tx_start`  out  1  one-cycle pulse, start transmission of `o_tx_data`
- `o_busy`  out  1  high in EXEC and WAIT_TX

## Operation
- **States:** WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX. Reset state is WAIT_A.
- **Reset values:** all outputs are 0, including `o_tx_start` and `o_busy`.
- **WAIT_A:** on `i_rx_done`, `o_data_a` <= `i_rx_data` and the state moves to WAIT_B.
- **WAIT_B:** on `i_rx_done`, `o_data_b` <= `i_rx_data` and the state moves to WAIT_OP.
- **WAIT_OP:** on `i_rx_done`, `o_op` <= `i_rx_data[NB_OP-1:0]` and the state moves to EXEC. The upper byte bits are discarded.
- **EXEC:** unconditional, one cycle.
  - `o_tx_data` <= `i_alu_result`.
  - `o_tx_start` <= 1.
  - The state moves to WAIT_TX.
- **WAIT_TX:** `o_tx_start` <= 0. On `i_tx_done` the state moves to WAIT_A.
- **Ignored events:**
  - `i_rx_done` in EXEC or WAIT_TX is ignored, so the byte is dropped and no operand register changes.
  - `i_tx_done` outside WAIT_TX is ignored.
- **Simultaneous `i_rx_done` and `i_tx_done` in WAIT_TX:** go to WAIT_A and drop the byte. It is not captured as A.
- **Register hold:** operand and opcode registers keep their values across transactions until overwritten. `o_tx_data` holds until the next EXEC.
- **Reset asserted mid-transaction:** all registers are cleared. The first byte after release is operand A.

## Timing
- **Per-byte latency:** an operand or opcode register is updated on the same rising edge that samples `i_rx_done`=1.
- **Opcode byte sampled at edge n:**
  - EXEC occupies cycle n..n+1.
  - `o_tx_data` is valid and `o_tx_start`=1 from edge n+1 to edge n+2 (exactly one cycle).
- **ALU settling:** the ALU has one full cycle to settle on the new `o_op` before the result is captured.
- **`o_busy`:** rises at edge n and falls on the edge that samples `i_tx_done`.
- **Back-to-back bytes:** `i_rx_done` may arrive on consecutive cycles in WAIT_A/B/OP and each is accepted.
- **Minimum turnaround:** 2 cycles from the opcode byte to the `o_tx_start` pulse (EXEC, then the registered start). `o_tx_start` is never asserted for two consecutive cycles.

## Configuration
- Macro: `ALU_UART_IF_TIMEOUT_EN`.
- **Defined:**
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` runs in WAIT_B and WAIT_OP.
  - It clears on every accepted `i_rx_done` and on entering either state.
  - When it reaches `TIMEOUT_CYCLES` with no byte, the state returns to WAIT_A, the counter clears and the operand registers are left unchanged.
  - A byte arriving on the timeout cycle itself is accepted, and the timeout is ignored.
- **Not defined:** no counter exists and the block waits indefinitely in WAIT_B/WAIT_OP.

## Test plan
- **Basic transaction:** send bytes 0x01, 0x01, 0x20 with the ALU model returning A+B.
  - `o_data_a`=0x01, `o_data_b`=0x01, `o_op`=0x20.
  - `o_tx_data`=0x02 with a single-cycle `o_tx_start` 2 cycles after the opcode pulse.
  - After `i_tx_done`, `o_busy`=0.
- **Opcode truncation:** opcode byte 0xE2 (NB_OP=6) -> `o_op`=0x22.
- **Dropped bytes while busy:** send 0x55 via `i_rx_done` during WAIT_TX.
  - `o_data_a` is unchanged.
  - After `i_tx_done`, bytes 0x03, 0x04, 0x20 produce `o_tx_data`=0x07.
- **Simultaneous events in WAIT_TX:** `i_rx_done` (0x09) and `i_tx_done` in the same cycle -> state WAIT_A and `o_data_a` not updated. The next byte 0x0A lands in `o_data_a`.
- **Reset mid-transaction:** drive `i_reset` low asynchronously (between edges) after operand A=0x11.
  - All outputs are 0 immediately.
  - After release, bytes 0x05, 0x06, 0x20 yield `o_tx_data`=0x0B.
- **Timeout** (macro defined, TIMEOUT_CYCLES=16): send A=0x01 then idle 16 cycles -> back in WAIT_A, so the next byte 0x02 is taken as A. Without the macro, the same byte is taken as B.
